fpu_job_scheduler: RTL and testbench

Shares one dot-product FPU datapath, (I1*I2)+(I3*I4) with fixed pipeline latency, between NUM_REQ independent requesters. Round-robin arbitration picks one job at a time. The block latches that job's four operands and holds them stable on the datapath inputs, times the result by latency count rather than the datapath valid, and returns the result tagged with the requester ID. One job in flight; it sits between the byte-serial I/O front end and the FPU top.

---
 rtl/fpu_job_scheduler.sv | 172 +++++++++++++++++
 tb/tb_fpu_job_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_job_scheduler.sv
// Round-robin job scheduler sharing one fixed-latency dot-product FPU among NUM_REQ requesters.
// Optional `ifdef FPU_SCHED_STATS_EN adds saturating job_count / stall_count outputs.
//
// state | meaning
// IDLE  | arbitrating; req_ready one-hot to the winner
// ISSUE | operands latched, fpu_start pulse
// WAIT  | counting down the datapath latency
// RESP  | result held until resp_ready
module fpu_job_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 2,
  parameter int ID_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [128*NUM_REQ-1:0] req_ops,
  output logic [127:0]           fpu_ops,
  output logic                   fpu_start,
  input  logic [31:0]            fpu_out,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_data,
  output logic                   resp_zero,
  output logic                   busy
`ifdef FPU_SCHED_STATS_EN
  ,
  output logic [15:0]            job_count,
  output logic [15:0]            stall_count
`endif
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     fpu_ops_q, fpu_ops_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_zero_q, resp_zero_d;

  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [127:0]     ops_sel;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    ops_sel   = '0;
    req_ready = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
        ops_sel   = req_ops[idx*128 +: 128];
        if (state_q == S_IDLE) req_ready[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    fpu_ops_d   = fpu_ops_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_zero_d = resp_zero_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          fpu_ops_d = ops_sel;
          id_d      = grant_id;
          rr_ptr_d  = grant_id;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Result timed by latency alone; the datapath valid is low for zero results.
        if (cnt_q == '0) begin
          resp_data_d = fpu_out;
          resp_zero_d = (fpu_out[30:0] == 31'd0);
          resp_id_d   = id_q;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= PTR_INIT;
      id_q        <= '0;
      cnt_q       <= '0;
      fpu_ops_q   <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      fpu_ops_q   <= fpu_ops_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_zero_q <= resp_zero_d;
    end
  end

  assign fpu_ops    = fpu_ops_q;
  assign fpu_start  = (state_q == S_ISSUE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign busy       = (state_q != S_IDLE);

`ifdef FPU_SCHED_STATS_EN
  logic [15:0] job_count_q, job_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    job_count_d   = job_count_q;
    stall_count_d = stall_count_q;
    if (state_q == S_RESP && resp_ready && job_count_q != 16'hFFFF)
      job_count_d = job_count_q + 16'd1;
    if (state_q == S_RESP && !resp_ready && stall_count_q != 16'hFFFF)
      stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      job_count_q   <= job_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign job_count   = job_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fpu_job_scheduler.sv
// Directed bench for fpu_job_scheduler: vector table of jobs plus reset and backpressure sequences.
// The FPU is stood in for by a two-stage pipe whose output is valid only in the correct cycle.
module tb_fpu_job_scheduler;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_ops;
  logic [127:0] fpu_ops;
  logic         fpu_start;
  logic [31:0]  fpu_out;
  logic         resp_valid;
  logic         resp_ready;
  logic [2:0]   resp_id;
  logic [31:0]  resp_data;
  logic         resp_zero;
  logic         busy;
`ifdef FPU_SCHED_STATS_EN
  logic [15:0]  job_count;
  logic [15:0]  stall_count;
`endif

  fpu_job_scheduler #(.NUM_REQ(2), .LATENCY(2), .ID_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ops(req_ops),
    .fpu_ops(fpu_ops), .fpu_start(fpu_start), .fpu_out(fpu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .busy(busy)
`ifdef FPU_SCHED_STATS_EN
    , .job_count(job_count), .stall_count(stall_count)
`endif
  );

  localparam logic [127:0] OPS_A = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] OPS_Z = {32'h40800000, 32'h00000000, 32'h40000000, 32'h00000000};
  localparam logic [127:0] OPS_B = {32'h00000000, 32'h00000000, 32'h00000F00, 32'h12345678};
  localparam logic [127:0] OPS_C = {32'h00000000, 32'h00000000, 32'h0000BBBB, 32'hAAAA0000};
  localparam logic [127:0] OPS_D = {32'h00000000, 32'h44444444, 32'h22222222, 32'h11111111};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in datapath: real result for OPS_A, zero when I1 and I3 are zero, else XOR of lanes.
  function automatic logic [31:0] fake_fpu(input logic [127:0] ops);
    if (ops == OPS_A) return 32'h41600000;
    if (ops[31:0] == 32'd0 && ops[95:64] == 32'd0) return 32'd0;
    return ops[31:0] ^ ops[63:32] ^ ops[95:64] ^ ops[127:96];
  endfunction

  logic [31:0] p0 = 32'd0, p1 = 32'd0;
  logic        v0 = 1'b0, v1 = 1'b0;
  always @(posedge clk) begin
    p0 <= fake_fpu(fpu_ops);
    v0 <= fpu_start;
    p1 <= p0;
    v1 <= v0;
  end
  assign fpu_out = v1 ? p1 : 32'hDEADBEEF;

  int n_checks = 0;
  int n_fail   = 0;
  int last_acc = -1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [1:0]   valid;
    logic [127:0] ops0;
    logic [127:0] ops1;
    logic [1:0]   exp_ready;
    logic [2:0]   exp_id;
    logic [31:0]  exp_data;
    logic         exp_zero;
    logic         scramble;
  } vec_t;

  vec_t vecs [8];

  task automatic run_job(input vec_t v);
    int n;
    int k;
    logic [127:0] exp_ops;
    exp_ops    = (v.exp_ready == 2'b01) ? v.ops0 : v.ops1;
    req_valid  = v.valid;
    req_ops    = {v.ops1, v.ops0};
    resp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      step();
      n++;
    end
    chk("accept_wait", (n < 20), 1);
    chk("req_ready", req_ready, v.exp_ready);
    if (last_acc >= 0) chk("job_period", cyc - last_acc, 5);
    last_acc = cyc;
    step();
    chk("fpu_start_issue", fpu_start, 1);
    chk("fpu_ops_issue", fpu_ops, exp_ops);
    chk("req_ready_busy", req_ready, 0);
    chk("busy", busy, 1);
    k = 1;
    step();
    k++;
    chk("fpu_start_pulse", fpu_start, 0);
    if (v.scramble) begin
      req_ops[127:0] = ~v.ops0;
      #1;
    end
    while (!resp_valid && k < 12) begin
      chk("fpu_ops_hold", fpu_ops, exp_ops);
      step();
      k++;
    end
    chk("accept_to_resp", k, 4);
    chk("resp_data", resp_data, v.exp_data);
    chk("resp_id", resp_id, v.exp_id);
    chk("resp_zero", resp_zero, v.exp_zero);
    step();
    chk("resp_valid_drop", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{2'b01, OPS_A, OPS_B, 2'b01, 3'd0, 32'h41600000, 1'b0, 1'b0};
    vecs[1] = '{2'b01, OPS_Z, OPS_B, 2'b01, 3'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{2'b10, OPS_A, OPS_B, 2'b10, 3'd1, 32'h12345978, 1'b0, 1'b0};
    vecs[3] = '{2'b10, OPS_A, OPS_C, 2'b10, 3'd1, 32'hAAAABBBB, 1'b0, 1'b0};
    vecs[4] = '{2'b11, OPS_D, OPS_C, 2'b01, 3'd0, 32'h77777777, 1'b0, 1'b0};
    vecs[5] = '{2'b11, OPS_D, OPS_C, 2'b10, 3'd1, 32'hAAAABBBB, 1'b0, 1'b0};
    vecs[6] = '{2'b11, OPS_A, OPS_C, 2'b01, 3'd0, 32'h41600000, 1'b0, 1'b1};
    vecs[7] = '{2'b11, OPS_A, OPS_B, 2'b10, 3'd1, 32'h12345978, 1'b0, 1'b0};

    rst        = 1'b1;
    req_valid  = 2'b00;
    req_ops    = '0;
    resp_ready = 1'b1;
    step();
    step();
    chk("rst_fpu_ops", fpu_ops, 0);
    chk("rst_fpu_start", fpu_start, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_zero", resp_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_job(vecs[i]);

    // Reset one cycle after fpu_start: job abandoned, pointer back to requester 0.
    req_valid = 2'b01;
    req_ops   = {OPS_B, OPS_A};
    #1;
    chk("mid_rst_accept", req_ready, 2'b01);
    step();
    chk("mid_rst_start", fpu_start, 1);
    step();
    rst       = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_fpu_ops", fpu_ops, 0);
    chk("mid_rst_resp_data", resp_data, 0);
    chk("mid_rst_resp_id", resp_id, 0);
    chk("mid_rst_fpu_start", fpu_start, 0);
    step();
    rst = 1'b0;
    last_acc = -1;
    run_job('{2'b11, OPS_A, OPS_B, 2'b01, 3'd0, 32'h41600000, 1'b0, 1'b0});

    // Backpressure: six stalled RESP cycles.
    rst       = 1'b1;
    req_valid = 2'b00;
    step();
    rst        = 1'b0;
    req_valid  = 2'b01;
    req_ops    = {OPS_B, OPS_C};
    resp_ready = 1'b0;
    #1;
    chk("bp_accept", req_ready, 2'b01);
    step();
    n = 0;
    while (!resp_valid && n < 12) begin
      step();
      n++;
    end
    chk("bp_resp_wait", (n < 12), 1);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_data", resp_data, 32'hAAAABBBB);
      chk("bp_resp_id", resp_id, 0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_fpu_ops", fpu_ops, OPS_C);
      step();
    end
    resp_ready = 1'b1;
    #1;
`ifdef FPU_SCHED_STATS_EN
    chk("bp_stall_count", stall_count, 6);
    chk("bp_job_count_before", job_count, 0);
`endif
    step();
    chk("bp_release", resp_valid, 0);
`ifdef FPU_SCHED_STATS_EN
    chk("bp_job_count", job_count, 1);
    chk("bp_stall_hold", stall_count, 6);
`endif
    chk("bp_next_grant", req_ready, 2'b10);
    req_valid = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
